// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 commands, pet state codes, FSM state types and text ROM helpers
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC  = 8'h38;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_CLR   = 8'h01;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_LINE1 = 8'h80;
   localparam logic [7:0] CMD_LINE2 = 8'hC0;

   localparam logic [2:0] ST_NORMAL     = 3'd0;
   localparam logic [2:0] ST_HAMBRIENTO = 3'd1;
   localparam logic [2:0] ST_ENFERMO    = 3'd2;
   localparam logic [2:0] ST_DORMIDO    = 3'd3;
   localparam logic [2:0] ST_JUGANDO    = 3'd4;
   localparam logic [2:0] ST_FELIZ      = 3'd5;
   localparam logic [2:0] ST_TEST       = 3'd6;
   localparam logic [2:0] ST_MUERTO     = 3'd7;

   localparam logic [2:0] BAR_LEN  = 3'd5;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_BLOCK = 8'hFF;

   typedef enum logic [1:0] {W_IDLE, W_SETUP, W_PULSE, W_HOLD} wr_state_t;
   typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2} lcd_state_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      return i == 2'd0 ? CMD_FUNC : i == 2'd1 ? CMD_DISP : i == 2'd2 ? CMD_CLR : CMD_ENTRY;
   endfunction

   function automatic logic [7:0] line1_char(input logic [2:0] code, input logic [3:0] idx);
      logic [127:0] t;
      case (code)
         ST_NORMAL:     t = {"NORMAL",     {10{CH_SPACE}}};
         ST_HAMBRIENTO: t = {"HAMBRIENTO", {6{CH_SPACE}}};
         ST_ENFERMO:    t = {"ENFERMO",    {9{CH_SPACE}}};
         ST_DORMIDO:    t = {"DORMIDO",    {9{CH_SPACE}}};
         ST_JUGANDO:    t = {"JUGANDO",    {9{CH_SPACE}}};
         ST_FELIZ:      t = {"FELIZ",      {11{CH_SPACE}}};
         ST_TEST:       t = {"TEST",       {12{CH_SPACE}}};
         default:       t = {"MUERTO",     {10{CH_SPACE}}};
      endcase
      t = t << {idx, 3'b000};
      return t[127:120];
   endfunction

   function automatic logic [7:0] bar_char(input logic [2:0] level, input logic [2:0] pos);
      logic [2:0] lim;
      lim = (level > BAR_LEN) ? BAR_LEN : level;
      return (pos < lim) ? CH_BLOCK : CH_SPACE;
   endfunction

   // Line 2 layout: "H:" bar(h) " A:" bar(a) " "
   function automatic logic [7:0] line2_char(input logic [2:0] h, input logic [2:0] a, input logic [3:0] idx);
      return idx == 4'd0 ? 8'h48 :
             idx == 4'd1 ? 8'h3A :
             idx <  4'd7 ? bar_char(h, 3'(idx - 4'd2)) :
             idx == 4'd7 ? CH_SPACE :
             idx == 4'd8 ? 8'h41 :
             idx == 4'd9 ? 8'h3A :
             idx < 4'd15 ? bar_char(a, 3'(idx - 4'd10)) : CH_SPACE;
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one HD44780 byte transfer as SETUP / PULSE / HOLD with start/done handshake
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int EN_CYC  = 25,
   parameter int CMD_CYC = 2500,
   parameter int CLR_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rs_in,
   input  logic [7:0] data_in,
   output logic       rs,
   output logic [7:0] data,
   output logic       enable,
   output logic       done
);

   localparam int MAXW = (CLR_CYC > CMD_CYC ? CLR_CYC : CMD_CYC) > EN_CYC ?
                         (CLR_CYC > CMD_CYC ? CLR_CYC : CMD_CYC) : EN_CYC;
   localparam int CW = $clog2(MAXW) + 1;

   wr_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_n, hold_last;

   assign hold_last = (!rs && data == CMD_CLR) ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);
   assign enable    = (state == W_PULSE);

   // Phase register; rs/data latch only on start so they stay put for the whole transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= W_IDLE;
         cnt   <= '0;
         rs    <= 1'b0;
         data  <= 8'h00;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (start) begin
            rs   <= rs_in;
            data <= data_in;
         end
      end
   end

   // Phase sequencing; done marks the last HOLD cycle so a new start chains with no gap
   always_comb begin
      state_n = state;
      cnt_n   = '0;
      done    = 1'b0;
      case (state)
         W_IDLE:  state_n = start ? W_SETUP : W_IDLE;
         W_SETUP: state_n = W_PULSE;
         W_PULSE: begin
            state_n = (cnt == CW'(EN_CYC - 1)) ? W_HOLD : W_PULSE;
            cnt_n   = (cnt == CW'(EN_CYC - 1)) ? '0 : cnt + 1'b1;
         end
         default: begin
            done    = (cnt == hold_last);
            state_n = !done ? W_HOLD : start ? W_SETUP : W_IDLE;
            cnt_n   = done ? '0 : cnt + 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/lcd_state_writer.sv
// lcd_state_writer: power-up/init of an HD44780 and refresh of the pet status text.
// Build macro LCD_LINE2_EN adds line 2 (health/food bars) to every refresh.
module lcd_state_writer
   import lcd_pkg::*;
#(
   parameter int EN_CYC    = 25,
   parameter int CMD_CYC   = 2500,
   parameter int CLR_CYC   = 100000,
   parameter int PWRUP_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] state_code,
   input  logic [2:0] level_h,
   input  logic [2:0] level_a,
   input  logic       upd_req,
   output logic       rs,
   output logic       rw,
   output logic [7:0] data,
   output logic       enable,
   output logic       busy
);

   localparam int PW = $clog2(PWRUP_CYC) + 1;

   lcd_state_t    state, state_n;
   logic [PW-1:0] cnt, cnt_n;
   logic [3:0]    idx, idx_n;
   logic          pend, pend_n, take, changed, refreshing;
   logic [2:0]    snap_s, snap_h, snap_a;
   logic          start, done, b_rs;
   logic [7:0]    b_data;

   assign rw         = 1'b0;
   assign busy       = (state != IDLE);
   assign refreshing = state inside {ADDR1, LINE1, ADDR2, LINE2};

`ifdef LCD_LINE2_EN
   assign changed = {state_code, level_h, level_a} != {snap_s, snap_h, snap_a};
`else
   assign changed = state_code != snap_s;
`endif

   lcd_byte_writer #(
      .EN_CYC (EN_CYC),
      .CMD_CYC(CMD_CYC),
      .CLR_CYC(CLR_CYC)
   ) u_wr (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .rs_in  (b_rs),
      .data_in(b_data),
      .rs     (rs),
      .data   (data),
      .enable (enable),
      .done   (done)
   );

   // Sequencer state, power-up counter, byte index, pending flag and displayed snapshot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= PWRUP;
         cnt    <= '0;
         idx    <= '0;
         pend   <= 1'b0;
         snap_s <= '0;
         snap_h <= '0;
         snap_a <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         pend  <= pend_n;
         if (take) begin
            snap_s <= state_code;
            snap_h <= level_h;
            snap_a <= level_a;
         end
      end
   end

   // Next byte selection: each byte is issued in the cycle the previous one reports done
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      pend_n  = pend;
      take    = 1'b0;
      start   = 1'b0;
      b_rs    = 1'b0;
      b_data  = 8'h00;
      case (state)
         PWRUP: begin
            if (cnt == PW'(PWRUP_CYC - 1)) begin
               start   = 1'b1;
               b_data  = CMD_FUNC;
               state_n = INIT;
               idx_n   = '0;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         INIT: begin
            if (done && idx == 4'd3) begin
               state_n = IDLE;
               pend_n  = 1'b1;
            end else if (done) begin
               idx_n  = idx + 4'd1;
               start  = 1'b1;
               b_data = init_cmd(idx[1:0] + 2'd1);
            end
         end
         IDLE: begin
            if (pend || upd_req || changed) begin
               start   = 1'b1;
               b_data  = CMD_LINE1;
               state_n = ADDR1;
               pend_n  = 1'b0;
               take    = 1'b1;
            end
         end
         ADDR1: begin
            if (done) begin
               start   = 1'b1;
               b_rs    = 1'b1;
               b_data  = line1_char(snap_s, 4'd0);
               idx_n   = '0;
               state_n = LINE1;
            end
         end
         LINE1: begin
            if (done && idx == 4'd15) begin
`ifdef LCD_LINE2_EN
               start   = 1'b1;
               b_data  = CMD_LINE2;
               state_n = ADDR2;
`else
               state_n = IDLE;
`endif
            end else if (done) begin
               idx_n  = idx + 4'd1;
               start  = 1'b1;
               b_rs   = 1'b1;
               b_data = line1_char(snap_s, idx + 4'd1);
            end
         end
         ADDR2: begin
            if (done) begin
               start   = 1'b1;
               b_rs    = 1'b1;
               b_data  = line2_char(snap_h, snap_a, 4'd0);
               idx_n   = '0;
               state_n = LINE2;
            end
         end
         LINE2: begin
            if (done && idx == 4'd15) begin
               state_n = IDLE;
            end else if (done) begin
               idx_n  = idx + 4'd1;
               start  = 1'b1;
               b_rs   = 1'b1;
               b_data = line2_char(snap_h, snap_a, idx + 4'd1);
            end
         end
         default: state_n = PWRUP;
      endcase
      if (refreshing && (upd_req || changed)) pend_n = 1'b1;
   end

endmodule

// File: tb/tb_lcd_state_writer.sv
// tb_lcd_state_writer: randomized self-checking bench with a text-level reference model
module tb_lcd_state_writer;

   localparam int EN = 2, CMD = 4, CLR = 20, PWR = 100;
`ifdef LCD_LINE2_EN
   localparam bit L2 = 1'b1;
`else
   localparam bit L2 = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1, upd_req = 1'b0;
   logic [2:0] state_code = '0, level_h = '0, level_a = '0;
   logic       rs, rw, enable, busy;
   logic [7:0] data;

   int         n_cmp = 0, n_bad = 0, cyc = 0;
   logic [8:0] mq[$];
   int         mc[$];
   logic [8:0] exp_q[$];
   logic [8:0] cur;
   logic       prev_en = 1'b0;
   logic [2:0] ms, mh, ma;
   logic [7:0] init_cmds[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
   string      names[8] = '{"NORMAL", "HAMBRIENTO", "ENFERMO", "DORMIDO",
                            "JUGANDO", "FELIZ", "TEST", "MUERTO"};

   lcd_state_writer #(.EN_CYC(EN), .CMD_CYC(CMD), .CLR_CYC(CLR), .PWRUP_CYC(PWR)) dut (
      .clk(clk), .rst(rst), .state_code(state_code), .level_h(level_h), .level_a(level_a),
      .upd_req(upd_req), .rs(rs), .rw(rw), .data(data), .enable(enable), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Capture every enable pulse and check rs/data/rw hold across it
   always @(negedge clk) begin
      if (rst) prev_en = 1'b0;
      else begin
         if (enable && !prev_en) begin
            cur = {rs, data};
            mq.push_back(cur);
            mc.push_back(cyc);
            chk("rw", 32'(rw), 0);
         end else if (enable) chk("stable", 32'({rs, data}), 32'(cur));
         prev_en = enable;
      end
   end

   function automatic void build(input logic [2:0] s, h, a);
      string l1, l2;
      exp_q.delete();
      l1 = names[s];
      while (l1.len() < 16) l1 = {l1, " "};
      exp_q.push_back(9'h080);
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l1[i]});
      if (L2) begin
         exp_q.push_back(9'h0C0);
         l2 = "H:";
         for (int k = 0; k < 5; k++) l2 = {l2, (k < ((h > 5) ? 5 : h)) ? 8'hFF : 8'h20};
         l2 = {l2, " A:"};
         for (int k = 0; k < 5; k++) l2 = {l2, (k < ((a > 5) ? 5 : a)) ? 8'hFF : 8'h20};
         l2 = {l2, " "};
         for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, l2[i]});
      end
   endfunction

   task automatic wait_pulses(input int n);
      for (int i = 0; i < 3000 && mq.size() < n; i++) @(negedge clk);
   endtask

   task automatic no_pulses(input int n);
      repeat (n) @(negedge clk);
      chk("quiet", mq.size(), 0);
      chk("idle_busy", 32'(busy), 0);
      mq.delete();
      mc.delete();
   endtask

   task automatic do_init(input int rel);
      int c, prev;
      int gaps[3];
      gaps = '{1 + EN + CMD, 1 + EN + CMD, 1 + EN + CLR};
      prev = 0;
      wait_pulses(4);
      chk("init_n", mq.size(), 4);
      for (int i = 0; i < 4 && mq.size() > 0; i++) begin
         c = mc.pop_front();
         if (i == 0) chk("init_t0", c - rel, PWR + 1);
         else chk("init_gap", c - prev, gaps[i-1]);
         chk("init_byte", 32'(mq.pop_front()), {23'd0, 1'b0, init_cmds[i]});
         prev = c;
      end
   endtask

   task automatic expect_refresh(input logic [2:0] s, h, a, output int r);
      int n, c, prev;
      build(s, h, a);
      wait_pulses(exp_q.size());
      n = (mq.size() < exp_q.size()) ? mq.size() : exp_q.size();
      chk("ref_n", n, exp_q.size());
      r = (n > 0) ? mc[0] : -1;
      prev = r;
      for (int i = 0; i < n; i++) begin
         c = mc.pop_front();
         if (i > 0) chk("ref_gap", c - prev, 1 + EN + CMD);
         chk("ref_byte", 32'(mq.pop_front()), 32'(exp_q[i]));
         prev = c;
      end
   endtask

   task automatic busy_fall(input int r);
      for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
      chk("busy_fall", cyc - r + 1, exp_q.size() * (1 + EN + CMD));
   endtask

   task automatic step(input logic [2:0] s, h, a, input logic u);
      int c, r;
      logic e;
      @(negedge clk);
      state_code = s; level_h = h; level_a = a; upd_req = u;
      c = cyc;
      e = u || s != ms || (L2 && (h != mh || a != ma));
      @(negedge clk);
      upd_req = 1'b0;
      if (e) begin
         expect_refresh(s, h, a, r);
         chk("start_lat", r - c, 2);
         busy_fall(r);
         ms = s; mh = h; ma = a;
      end else no_pulses(30);
   endtask

   initial begin
      int r, rel;
      logic [2:0] ns;
      repeat (3) @(negedge clk);
      chk("rst_rs", 32'(rs), 0);
      chk("rst_rw", 32'(rw), 0);
      chk("rst_data", 32'(data), 0);
      chk("rst_en", 32'(enable), 0);
      chk("rst_busy", 32'(busy), 1);
      state_code = 3'd1; level_h = 3'd3; level_a = 3'd7;
      rel = cyc;
      rst = 1'b0;
      do_init(rel);
      expect_refresh(3'd1, 3'd3, 3'd7, r);
      busy_fall(r);
      ms = 3'd1; mh = 3'd3; ma = 3'd7;
      step(3'd0, mh, ma, 1'b0);
      step(3'd7, mh, ma, 1'b0);
      step(ms, mh + 3'd1, ma, 1'b0);
      step(ms, mh, ma, 1'b0);
      for (int i = 0; i < 12; i++) begin
         ns = ($urandom_range(1) == 0) ? ms : 3'($urandom_range(7));
         step(ns, 3'($urandom_range(7)), 3'($urandom_range(7)), $urandom_range(3) == 0);
      end
      @(negedge clk); upd_req = 1'b1;
      @(negedge clk); upd_req = 1'b0;
      wait_pulses(10);
      ns = ms + 3'd3;
      state_code = ns; upd_req = 1'b1;
      @(negedge clk); upd_req = 1'b0;
      expect_refresh(ms, mh, ma, r);
      expect_refresh(ns, mh, ma, r);
      ms = ns;
      no_pulses(60);
      @(negedge clk); upd_req = 1'b1;
      @(negedge clk); upd_req = 1'b0;
      for (int i = 0; i < 100 && !enable; i++) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_en", 32'(enable), 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_en", 32'(enable), 0);
      chk("rst_mid_busy", 32'(busy), 1);
      chk("rst_mid_data", 32'(data), 0);
      @(negedge clk); @(negedge clk);
      mq.delete(); mc.delete();
      rel = cyc;
      rst = 1'b0;
      do_init(rel);
      expect_refresh(ms, mh, ma, r);
      busy_fall(r);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_state_writer.md
LCD_STATE_WRITER -- requirements
Module: lcd_state_writer

Interface
REQ-001 Parameter EN_CYC, default 25, enable high-pulse width in clk cycles.
REQ-002 Parameter CMD_CYC, default 2500, post-pulse wait for every byte except clear, in clk cycles.
REQ-003 Parameter CLR_CYC, default 100000, post-pulse wait after command 0x01, in clk cycles.
REQ-004 Parameter PWRUP_CYC, default 1000000, wait after reset release before the first byte, in clk cycles.
REQ-005 clk  in  1  single system clock, 50 MHz nominal.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 state_code  in  3  pet state from the game FSM, selects the line-1 text.
REQ-008 level_h  in  3  health level 0..7.
REQ-009 level_a  in  3  food level 0..7.
REQ-010 upd_req  in  1  one-cycle forced refresh request.
REQ-011 rs  out  1  HD44780 register select: 0 = command, 1 = data.
REQ-012 rw  out  1  HD44780 read/write, permanently 0.
REQ-013 data  out  8  HD44780 data bus.
REQ-014 enable  out  1  HD44780 strobe.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The top FSM shall use the states PWRUP -> INIT -> IDLE -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> IDLE.
REQ-017 PWRUP shall hold for PWRUP_CYC cycles, then go to INIT.
REQ-018 INIT shall send the commands 0x38, 0x0C, 0x01, 0x06, in that order.
REQ-019 Each byte transfer shall run three phases:
- SETUP: 1 cycle, rs/data valid, enable=0.
- PULSE: EN_CYC cycles, enable=1.
- HOLD: CMD_CYC cycles (CLR_CYC for 0x01), enable=0.
REQ-020 rs and data shall stay stable for the whole of every byte transfer.
REQ-021 In IDLE, the block shall start a refresh when upd_req=1, or when {state_code, level_h, level_a} differs from the last displayed snapshot.
REQ-022 The snapshot shall be taken in the cycle the refresh starts.
REQ-023 A refresh shall send:
- command 0x80;
- 16 data bytes of line-1 text;
- command 0xC0;
- 16 data bytes of line-2 text.
REQ-024 Line-1 text shall be left-justified and space-padded (0x20) to 16 characters, indexed by state_code:
- 0 "NORMAL", 1 "HAMBRIENTO", 2 "ENFERMO", 3 "DORMIDO";
- 4 "JUGANDO", 5 "FELIZ", 6 "TEST", 7 "MUERTO".
REQ-025 Line-2 text shall be "H:" + bar(level_h) + " A:" + bar(level_a) + " ".
REQ-026 bar(n) shall be min(n,5) characters of 0xFF followed by space padding to 5 characters; levels 6 and 7 clamp to 5.
REQ-027 An upd_req or input change during a refresh shall set a pending flag; on reaching IDLE, the block shall start a new refresh on the next cycle.
REQ-028 The pending flag shall be cleared when that refresh starts.
REQ-029 Inputs shall be ignored (not latched, no pending flag set) during PWRUP and INIT.
REQ-030 The first refresh after INIT shall be unconditional.

Reset
REQ-031 While rst=1, outputs shall be rs=0, rw=0, data=0x00, enable=0, busy=1.
REQ-032 While rst=1, the FSM shall be in PWRUP, all counters at 0, the pending flag cleared, and the snapshot cleared.
REQ-033 Assertion of rst mid-transfer shall drop enable immediately.
REQ-034 After rst release, the block shall restart the full power-up and init sequence.

Configuration
REQ-035 Macro LCD_LINE2_EN defined: the refresh includes ADDR2 and LINE2 (34 bytes).
REQ-036 Macro LCD_LINE2_EN undefined: the refresh ends after LINE1 (17 bytes); level_h and level_a are excluded from change detection.

Structure
REQ-037 Package lcd_pkg shall hold:
- HD44780 command constants (0x38, 0x0C, 0x01, 0x06, 0x80, 0xC0);
- state-code constants 0..7;
- the line-1 text ROM function;
- the bar-length constant 5.
REQ-038 The sub-module lcd_byte_writer shall implement the SETUP/PULSE/HOLD phases with a start/done handshake; the top FSM shall issue the next byte only after done.

Verification
REQ-039 Bench parameters: EN_CYC=2, CMD_CYC=4, CLR_CYC=20, PWRUP_CYC=100.
REQ-040 Init timing: release rst -> first enable rise at cycle 101; four enable pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs=0; the gap after 0x01 is 20 cycles.
REQ-041 Unconditional refresh: after INIT, with state_code=1, level_h=3, level_a=7 and LCD_LINE2_EN defined -> 34 pulses; line 1 = "HAMBRIENTO" plus 6 spaces; line 2 = "H:" + 0xFF×3 + 2 spaces + " A:" + 0xFF×5 + " "; busy falls after 34×7 cycles.
REQ-042 Change during refresh: in IDLE, change state_code 0->7 -> refresh starts next cycle; pulse upd_req mid-refresh -> exactly one further refresh follows.
REQ-043 Reset mid-transfer: assert rst during a PULSE phase -> enable=0 within the same cycle; after release -> the 100-cycle wait and 0x38 occur again.
REQ-044 Macro off: build without LCD_LINE2_EN, change level_h only -> no refresh; change state_code -> 17 pulses, no 0xC0 sent.
